stream_framer: RTL and testbench



---
 rtl/stream_framer.sv | 191 +++++++++++++++++++
 tb/tb_stream_framer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : stream_framer
// Description : Source-side framer for the CNN streaming interface. Takes a
//               raw beat stream, counts beats per pixel, pixels per line and
//               lines per frame, and emits the beat one cycle later tagged
//               with sop/eop/sof/eof. Synchronises on frame_start_i and
//               pulses trunc_o when a frame is aborted before its eof.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-high reset
//   data_i         in   raw beat (DATA_WIDTH)
//   data_valid_i   in   raw beat valid
//   frame_start_i  in   next (or same-cycle) valid beat starts a frame
//   data_o         out  registered beat, holds when data_valid_o=0
//   data_valid_o   out  output beat valid
//   sop_o/eop_o    out  first / last beat of line
//   sof_o/eof_o    out  first / last beat of frame
//   trunc_o        out  one-cycle pulse, frame aborted before eof
//   busy_o         out  framer not in IDLE
//   err_clr_i      in   synchronous error counter clear (optional)
//   err_cnt_o      out  saturating error count [15:0] (optional)
//
// Optional feature macro: STREAM_FRAMER_ERR_CNT_EN adds err_clr_i/err_cnt_o.
// Markers are forced low whenever data_valid_o is low.
// ============================================================================
module stream_framer #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 3,
    parameter int STRING_LEN  = 224,
    parameter int STRING_NUM  = 224,
    parameter bit FREE_RUN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    input  logic                  frame_start_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  data_valid_o,
    output logic                  sop_o,
    output logic                  eop_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  trunc_o,
    output logic                  busy_o
`ifdef STREAM_FRAMER_ERR_CNT_EN
    ,
    input  logic                  err_clr_i,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int c_BEAT_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
    localparam int c_PIX_W  = (STRING_LEN  > 1) ? $clog2(STRING_LEN)  : 1;
    localparam int c_LINE_W = (STRING_NUM  > 1) ? $clog2(STRING_NUM)  : 1;

    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(CHANNEL_NUM - 1);
    localparam logic [c_PIX_W-1:0]  c_PIX_LAST  = c_PIX_W'(STRING_LEN - 1);
    localparam logic [c_LINE_W-1:0] c_LINE_LAST = c_LINE_W'(STRING_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic [c_PIX_W-1:0]    r_pix_cnt;
    logic [c_LINE_W-1:0]   r_line_cnt;

    logic                  w_cur_last;
    logic                  w_eof_restart;
    logic                  w_trunc;
    logic                  w_use_zero;
    logic                  w_fwd;
    logic                  w_drop;
    logic [c_BEAT_W-1:0]   w_beat;
    logic [c_PIX_W-1:0]    w_pix;
    logic [c_LINE_W-1:0]   w_line;
    logic                  w_sop;
    logic                  w_eop;
    logic                  w_sof;
    logic                  w_eof;

    always_comb begin
        w_cur_last    = (r_beat_cnt == c_BEAT_LAST) && (r_pix_cnt == c_PIX_LAST) &&
                        (r_line_cnt == c_LINE_LAST);
        // A frame start that coincides with the eof beat just re-arms; any
        // other frame start while active aborts the current frame.
        w_eof_restart = (r_state == ST_ACTIVE) && frame_start_i && data_valid_i && w_cur_last;
        w_trunc       = (r_state == ST_ACTIVE) && frame_start_i && !(data_valid_i && w_cur_last);
        // Outside ACTIVE, or on an abort, the beat is placed at frame position 0.
        w_use_zero    = (r_state != ST_ACTIVE) || w_trunc;
        w_fwd         = data_valid_i && ((r_state != ST_IDLE) || frame_start_i);
        w_drop        = data_valid_i && (r_state == ST_IDLE) && !frame_start_i;
        w_beat        = w_use_zero ? '0 : r_beat_cnt;
        w_pix         = w_use_zero ? '0 : r_pix_cnt;
        w_line        = w_use_zero ? '0 : r_line_cnt;
        w_sop         = (w_beat == '0) && (w_pix == '0);
        w_eop         = (w_beat == c_BEAT_LAST) && (w_pix == c_PIX_LAST);
        w_sof         = w_sop && (w_line == '0);
        w_eof         = w_eop && (w_line == c_LINE_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            sop_o        <= 1'b0;
            eop_o        <= 1'b0;
            sof_o        <= 1'b0;
            eof_o        <= 1'b0;
            trunc_o      <= 1'b0;
        end else begin
            data_valid_o <= w_fwd;
            sop_o        <= w_fwd && w_sop;
            eop_o        <= w_fwd && w_eop;
            sof_o        <= w_fwd && w_sof;
            eof_o        <= w_fwd && w_eof;
            trunc_o      <= w_trunc;
            if (w_fwd) begin
                data_o <= data_i;
            end

            if (w_fwd) begin
                if (w_eof) begin
                    r_beat_cnt <= '0;
                    r_pix_cnt  <= '0;
                    r_line_cnt <= '0;
                    r_state    <= (FREE_RUN || w_eof_restart) ? ST_ARMED : ST_IDLE;
                end else begin
                    r_state <= ST_ACTIVE;
                    if (w_beat == c_BEAT_LAST) begin
                        r_beat_cnt <= '0;
                        if (w_pix == c_PIX_LAST) begin
                            r_pix_cnt  <= '0;
                            r_line_cnt <= w_line + 1'b1;
                        end else begin
                            r_pix_cnt  <= w_pix + 1'b1;
                            r_line_cnt <= w_line;
                        end
                    end else begin
                        r_beat_cnt <= w_beat + 1'b1;
                        r_pix_cnt  <= w_pix;
                        r_line_cnt <= w_line;
                    end
                end
            end else if (w_trunc) begin
                r_beat_cnt <= '0;
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_state    <= ST_ARMED;
            end else if ((r_state == ST_IDLE) && frame_start_i) begin
                r_state <= ST_ARMED;
            end
        end
    end

    assign busy_o = (r_state != ST_IDLE);

`ifdef STREAM_FRAMER_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Drops only happen in IDLE and aborts only in ACTIVE, so at most one
    // increment per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (err_clr_i) begin
            r_err_cnt <= '0;
        end else if ((w_drop || w_trunc) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused;
    assign w_unused = w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_framer
// Description : Scoreboard bench for stream_framer. Instance A uses
//               CHANNEL_NUM=2, STRING_LEN=4, STRING_NUM=3 (24-beat frames),
//               instance B the same geometry with FREE_RUN=1. Stimulus pushes
//               expected beats; per-instance monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_framer;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  d;
        logic [3:0]  m;     // {sop, eop, sof, eof}
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_d = '0, b_d = '0;
    logic       a_v = 1'b0, b_v = 1'b0, a_fs = 1'b0, b_fs = 1'b0;
    logic [7:0] a_do, b_do;
    logic       a_vo, a_sop, a_eop, a_sof, a_eof, a_tr, a_busy;
    logic       b_vo, b_sop, b_eop, b_sof, b_eof, b_tr, b_busy;
`ifdef STREAM_FRAMER_ERR_CNT_EN
    logic        a_clr = 1'b0;
    logic [15:0] a_err, b_err;
`endif

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   a_trunc_seen = 0;
    logic a_tr_prev = 1'b0;
    logic [7:0] dv = 8'h10;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_framer #(.DATA_WIDTH(8), .CHANNEL_NUM(2), .STRING_LEN(4), .STRING_NUM(3), .FREE_RUN(1'b0)) u_a (
        .clk(clk), .reset(reset), .data_i(a_d), .data_valid_i(a_v), .frame_start_i(a_fs),
        .data_o(a_do), .data_valid_o(a_vo), .sop_o(a_sop), .eop_o(a_eop), .sof_o(a_sof),
        .eof_o(a_eof), .trunc_o(a_tr), .busy_o(a_busy)
`ifdef STREAM_FRAMER_ERR_CNT_EN
        , .err_clr_i(a_clr), .err_cnt_o(a_err)
`endif
    );

    stream_framer #(.DATA_WIDTH(8), .CHANNEL_NUM(2), .STRING_LEN(4), .STRING_NUM(3), .FREE_RUN(1'b1)) u_b (
        .clk(clk), .reset(reset), .data_i(b_d), .data_valid_i(b_v), .frame_start_i(b_fs),
        .data_o(b_do), .data_valid_o(b_vo), .sop_o(b_sop), .eop_o(b_eop), .sof_o(b_sof),
        .eof_o(b_eof), .trunc_o(b_tr), .busy_o(b_busy)
`ifdef STREAM_FRAMER_ERR_CNT_EN
        , .err_clr_i(1'b0), .err_cnt_o(b_err)
`endif
    );

    // Hand-derived markers for beat k of a 24-beat frame (8 beats per line).
    function automatic logic [3:0] mk(input int k);
        mk = {(k % 8) == 0, (k % 8) == 7, k == 0, k == 23};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_v = 1'b0; a_fs = 1'b0; b_v = 1'b0; b_fs = 1'b0;
`ifdef STREAM_FRAMER_ERR_CNT_EN
            a_clr = 1'b0;
`endif
        end
    endtask

    task automatic beat_a(input logic fs, input logic exp_out, input int k);
        exp_t e;
        @(negedge clk);
        a_d = dv; a_v = 1'b1; a_fs = fs;
        if (exp_out) begin
            e.cyc = 32'(cyc); e.d = dv; e.m = mk(k);
            qa.push_back(e);
        end
        dv = dv + 8'd1;
    endtask

    task automatic beat_b(input logic fs, input int k);
        exp_t e;
        @(negedge clk);
        b_d = dv; b_v = 1'b1; b_fs = fs;
        e.cyc = 32'(cyc); e.d = dv; e.m = mk(k);
        qb.push_back(e);
        dv = dv + 8'd1;
    endtask

    // Monitor A
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (a_vo) begin
                if (qa.size() == 0) begin
                    bad++;
                    $display("FAIL a_extra_beat got d=%0h m=%b required no beat", a_do, {a_sop, a_eop, a_sof, a_eof});
                end else begin
                    ea = qa.pop_front();
                    if (a_do !== ea.d || {a_sop, a_eop, a_sof, a_eof} !== ea.m || 32'(cyc) !== ea.cyc + 1) begin
                        bad++;
                        $display("FAIL a_beat got d=%0h m=%b cyc=%0d required d=%0h m=%b cyc=%0d",
                                 a_do, {a_sop, a_eop, a_sof, a_eof}, cyc, ea.d, ea.m, ea.cyc + 1);
                    end
                end
            end else if ({a_sop, a_eop, a_sof, a_eof} !== 4'b0) begin
                bad++;
                $display("FAIL a_idle_markers got=%b required=0000", {a_sop, a_eop, a_sof, a_eof});
            end
            if (a_tr) begin
                total++;
                if (a_tr_prev) begin
                    bad++;
                    $display("FAIL a_trunc_width got=2+ cycles required=1");
                end
                a_trunc_seen++;
            end
            a_tr_prev = a_tr;
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (b_vo) begin
                if (qb.size() == 0) begin
                    bad++;
                    $display("FAIL b_extra_beat got d=%0h required no beat", b_do);
                end else begin
                    eb = qb.pop_front();
                    if (b_do !== eb.d || {b_sop, b_eop, b_sof, b_eof} !== eb.m || 32'(cyc) !== eb.cyc + 1) begin
                        bad++;
                        $display("FAIL b_beat got d=%0h m=%b cyc=%0d required d=%0h m=%b cyc=%0d",
                                 b_do, {b_sop, b_eop, b_sof, b_eof}, cyc, eb.d, eb.m, eb.cyc + 1);
                    end
                end
            end else if ({b_sop, b_eop, b_sof, b_eof, b_tr} !== 5'b0) begin
                bad++;
                $display("FAIL b_idle_markers got=%b required=00000", {b_sop, b_eop, b_sof, b_eof, b_tr});
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(a_vo), 0);
        chk("rst_markers", 32'({a_sop, a_eop, a_sof, a_eof, a_tr}), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_data", 32'(a_do), 0);
        reset = 1'b0;
        idle(2);

        // T1: 24 continuous beats, frame_start with the first
        for (int k = 0; k < 24; k++) begin
            beat_a(k == 0, 1'b1, k);
            if (k == 5) chk("t1_busy_mid", 32'(a_busy), 1);
        end
        idle(1);
        chk("t1_busy_after", 32'(a_busy), 0);
        idle(2);

        // T2: valid toggling every cycle
        for (int k = 0; k < 24; k++) begin
            beat_a(k == 0, 1'b1, k);
            idle(1);
        end
        idle(2);
        chk("t2_busy_after", 32'(a_busy), 0);

        // T3: beats before frame_start are dropped; then armed start
        for (int k = 0; k < 5; k++) beat_a(1'b0, 1'b0, 0);
        idle(1);
        chk("t3_busy_idle", 32'(a_busy), 0);
        @(negedge clk); a_v = 1'b0; a_fs = 1'b1;
        idle(2);
        chk("t3_busy_armed", 32'(a_busy), 1);
        for (int k = 0; k < 24; k++) beat_a(1'b0, 1'b1, k);
        idle(2);

        // T4: frame_start with the beat at index 10 truncates
        chk("t4_trunc_before", 32'(a_trunc_seen), 0);
        for (int k = 0; k < 10; k++) beat_a(k == 0, 1'b1, k);
        for (int k = 0; k < 24; k++) beat_a(k == 0, 1'b1, k);
        idle(2);
        chk("t4_trunc_count", 32'(a_trunc_seen), 1);
        chk("t4_busy_after", 32'(a_busy), 0);
`ifdef STREAM_FRAMER_ERR_CNT_EN
        chk("err_cnt_six", 32'(a_err), 6);
        @(negedge clk); a_clr = 1'b1;
        idle(1);
        chk("err_cnt_clr", 32'(a_err), 0);
`endif

        // T5: frame_start coinciding with the eof beat re-arms, no truncation
        for (int k = 0; k < 24; k++) beat_a((k == 0) || (k == 23), 1'b1, k);
        idle(2);
        chk("t5_busy_armed", 32'(a_busy), 1);
        for (int k = 0; k < 24; k++) beat_a(1'b0, 1'b1, k);
        idle(2);
        chk("t5_trunc_count", 32'(a_trunc_seen), 1);
        chk("t5_busy_after", 32'(a_busy), 0);

        // T6: FREE_RUN instance, 48 beats after one frame_start
        for (int i = 0; i < 48; i++) beat_b(i == 0, i % 24);
        idle(2);
        chk("t6_busy_rearmed", 32'(b_busy), 1);

        idle(3);
        chk("qa_drained", 32'(qa.size()), 0);
        chk("qb_drained", 32'(qb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
